mem_access_ctrl: RTL and testbench

- Multi-requester controller that shares one memory device (single-port, registered read, 2**ADDRESS_W x DATA_W words) between NUM_REQ requesters.
- Arbitrates round-robin, then sequences each granted request as one or two single-beat device accesses; a dual request covers address and address+1.
- Never uses the device's dual enables; dual transfers are built from two single beats, so the device's internal dual offset state is never exercised.

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_access_ctrl_rr_arbiter.sv | 46 ++++
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_access_ctrl block: FSM state
// encoding, default widths and request-to-response latencies.
package mem_ctrl_pkg;

   localparam int DEF_ADDRESS_W = 2;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_NUM_REQ   = 2;

   // Cycles from the accept cycle to the rsp_valid cycle.
   localparam int LAT_WR_SINGLE = 2;
   localparam int LAT_RD_SINGLE = 3;
   localparam int LAT_WR_DUAL   = 3;
   localparam int LAT_RD_DUAL   = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE0 = 3'd1,
      ISSUE1 = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Expected latency of a request type.
   function automatic int rsp_latency(input logic write, input logic dual);
      if (write) return dual ? LAT_WR_DUAL : LAT_WR_SINGLE;
      return dual ? LAT_RD_DUAL : LAT_RD_SINGLE;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester after the most
// recently granted one. The pointer only moves when a grant is accepted.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] idx;
   logic             found;

   // Scan requesters starting just after the pointer; first valid one wins.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      found     = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

   // Pointer holds the last granted requester; reset makes requester 0 first.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) begin
         ptr <= PTR_W'(NUM_REQ - 1);
      end else if (accept) begin
         ptr <= grant_idx;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-requester controller sharing one single-port, registered-read memory.
// Requests are arbitrated round-robin and executed as one or two single-beat
// device accesses; the device dual enables are never used.
// Optional per-requester accept counters: define MEM_ACCESS_CTRL_GRANT_CNT_EN.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter  int ADDRESS_W = DEF_ADDRESS_W,
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int NUM_REQ   = DEF_NUM_REQ,
   localparam int PTR_W     = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef MEM_ACCESS_CTRL_GRANT_CNT_EN
   output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ-1:0]            req_dual,
   input  logic [NUM_REQ*ADDRESS_W-1:0]  req_addr,
   input  logic [NUM_REQ*2*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [2*DATA_W-1:0]           rsp_rdata,
   output logic [ADDRESS_W-1:0]          mem_address,
   output logic                          mem_write_en,
   output logic                          mem_read_en,
   output logic                          mem_write_dual_en,
   output logic                          mem_read_dual_en,
   output logic [DATA_W-1:0]             mem_data_wr,
   input  logic [DATA_W-1:0]             mem_data_rd
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   state_t                  state;
   logic [PTR_W-1:0]        owner;
   logic                    write_q;
   logic                    dual_q;
   logic [ADDRESS_W-1:0]    addr_q;
   logic [DATA_W-1:0]       wdata_hi_q;

   logic [NUM_REQ-1:0]      grant;
   logic [PTR_W-1:0]        win_idx;
   logic                    accept;

   logic                    sel_write;
   logic                    sel_dual;
   logic [ADDRESS_W-1:0]    sel_addr;
   logic [2*DATA_W-1:0]     sel_wdata;

   assign mem_write_dual_en = 1'b0;
   assign mem_read_dual_en  = 1'b0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (win_idx)
   );

   assign req_ready = (state == IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);

   // Route the winning requester's fields to the latch point.
   always_comb begin
      sel_write = 1'b0;
      sel_dual  = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_write = req_write[i];
            sel_dual  = req_dual[i];
            sel_addr  = req_addr[i*ADDRESS_W +: ADDRESS_W];
            sel_wdata = req_wdata[i*2*DATA_W +: 2*DATA_W];
         end
      end
   end

   // Transfer sequencer; device and response outputs are registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         owner        <= '0;
         write_q      <= 1'b0;
         dual_q       <= 1'b0;
         addr_q       <= '0;
         wdata_hi_q   <= '0;
         rsp_valid    <= '0;
         rsp_rdata    <= '0;
         mem_address  <= '0;
         mem_write_en <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_data_wr  <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  owner        <= win_idx;
                  write_q      <= sel_write;
                  dual_q       <= sel_dual;
                  addr_q       <= sel_addr;
                  wdata_hi_q   <= sel_wdata[2*DATA_W-1:DATA_W];
                  rsp_rdata    <= '0;
                  mem_address  <= sel_addr;
                  mem_write_en <= sel_write;
                  mem_read_en  <= !sel_write;
                  mem_data_wr  <= sel_wdata[DATA_W-1:0];
                  state        <= ISSUE0;
               end
            end
            ISSUE0: begin
               if (dual_q) begin
                  // Second beat: address wraps naturally at ADDRESS_W bits.
                  mem_address <= addr_q + ADDRESS_W'(1);
                  mem_data_wr <= wdata_hi_q;
                  state       <= ISSUE1;
               end else begin
                  mem_write_en <= 1'b0;
                  mem_read_en  <= 1'b0;
                  mem_address  <= '0;
                  mem_data_wr  <= '0;
                  if (write_q) begin
                     rsp_valid <= ONE << owner;
                     state     <= DONE;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            ISSUE1: begin
               mem_write_en <= 1'b0;
               mem_read_en  <= 1'b0;
               mem_address  <= '0;
               mem_data_wr  <= '0;
               if (write_q) begin
                  rsp_valid <= ONE << owner;
                  state     <= DONE;
               end else begin
                  // Beat0 read data arrives while beat1 is being issued.
                  rsp_rdata[DATA_W-1:0] <= mem_data_rd;
                  state                 <= DRAIN;
               end
            end
            DRAIN: begin
               if (dual_q) rsp_rdata[2*DATA_W-1:DATA_W] <= mem_data_rd;
               else        rsp_rdata[DATA_W-1:0]        <= mem_data_rd;
               rsp_valid <= ONE << owner;
               state     <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ACCESS_CTRL_GRANT_CNT_EN
   // Saturating per-requester count of accepted requests.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt <= '0;
      end else if (accept) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural single-port,
// registered-read memory that powers up / resets to all 8'hFF.
module tb_mem_access_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_write = '0;
   logic [NR-1:0]     req_dual  = '0;
   logic [NR*AW-1:0]  req_addr  = '0;
   logic [NR*2*DW-1:0] req_wdata = '0;
   logic [NR-1:0]     rsp_valid;
   logic [2*DW-1:0]   rsp_rdata;
   logic [AW-1:0]     mem_address;
   logic              mem_write_en;
   logic              mem_read_en;
   logic              mem_write_dual_en;
   logic              mem_read_dual_en;
   logic [DW-1:0]     mem_data_wr;
   logic [DW-1:0]     mem_data_rd;
`ifdef MEM_ACCESS_CTRL_GRANT_CNT_EN
   logic [NR*16-1:0]  grant_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_ctrl #(
      .ADDRESS_W (AW),
      .DATA_W    (DW),
      .NUM_REQ   (NR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
`ifdef MEM_ACCESS_CTRL_GRANT_CNT_EN
      .grant_cnt         (grant_cnt),
`endif
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_dual          (req_dual),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .mem_address       (mem_address),
      .mem_write_en      (mem_write_en),
      .mem_read_en       (mem_read_en),
      .mem_write_dual_en (mem_write_dual_en),
      .mem_read_dual_en  (mem_read_dual_en),
      .mem_data_wr       (mem_data_wr),
      .mem_data_rd       (mem_data_rd)
   );

   // Device model: reset is ~rst, contents reset to FF, read data one cycle late.
   logic [DW-1:0] dev_mem [0:3];
   logic          dev_rst;
   assign dev_rst = ~rst;

   always @(posedge clk or posedge dev_rst) begin
      if (dev_rst) begin
         for (int a = 0; a < 4; a++) dev_mem[a] <= 8'hFF;
         mem_data_rd <= '0;
      end else begin
         if (mem_write_en) dev_mem[mem_address] <= mem_data_wr;
         if (mem_read_en)  mem_data_rd <= dev_mem[mem_address];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   task automatic drive_req(input int i, input logic wr, input logic dual,
                            input logic [AW-1:0] addr, input logic [2*DW-1:0] wd);
      req_write[i]               = wr;
      req_dual[i]                = dual;
      req_addr[i*AW +: AW]       = addr;
      req_wdata[i*2*DW +: 2*DW]  = wd;
      req_valid[i]               = 1'b1;
   endtask

   // Issue one request, wait for accept and response, check latency/owner/data.
   task automatic do_req(input int i, input logic wr, input logic dual,
                         input logic [AW-1:0] addr, input logic [2*DW-1:0] wd,
                         input int exp_lat, input logic [2*DW-1:0] exp_rdata,
                         input string name);
      int t_acc;
      int k;
      logic [NR-1:0] exp_v;
      @(negedge clk);
      drive_req(i, wr, dual, addr, wd);
      #1;
      k = 0;
      while (req_ready[i] !== 1'b1 && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      checks++;
      if (k >= 20) begin
         failures++;
         $display("FAIL %s_accept: req_ready=%b, required bit %0d set", name, req_ready, i);
         req_valid[i] = 1'b0;
         return;
      end
      t_acc = cyc;
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      k = 0;
      @(negedge clk);
      while (rsp_valid === '0 && k < 12) begin
         @(negedge clk);
         k++;
      end
      exp_v    = '0;
      exp_v[i] = 1'b1;
      checks++;
      if (cyc - t_acc != exp_lat) begin
         failures++;
         $display("FAIL %s_latency: got %0d, required %0d", name, cyc - t_acc, exp_lat);
      end
      checks++;
      if (rsp_valid !== exp_v) begin
         failures++;
         $display("FAIL %s_rsp_valid: got %b, required %b", name, rsp_valid, exp_v);
      end
      checks++;
      if (rsp_rdata !== exp_rdata) begin
         failures++;
         $display("FAIL %s_rdata: got %h, required %h", name, rsp_rdata, exp_rdata);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin
         failures++;
         $display("FAIL %s_pulse: rsp_valid=%b one cycle later, required 0", name, rsp_valid);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, mem_address, mem_write_en, mem_read_en,
           mem_write_dual_en, mem_read_dual_en, mem_data_wr} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h a=%h we=%b re=%b wd=%h, required all 0",
                  req_ready, rsp_valid, rsp_rdata, mem_address, mem_write_en, mem_read_en, mem_data_wr);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, mem_write_en, mem_read_en} !== '0) begin
         failures++;
         $display("FAIL reset_idle: rv=%b we=%b re=%b, required 0", rsp_valid, mem_write_en, mem_read_en);
      end
   endtask

   task automatic test_single_read();
      do_req(0, 1'b0, 1'b0, 2'd2, 16'h0000, LAT_RD_SINGLE, 16'h00FF, "single_read");
   endtask

   task automatic test_dual();
      do_req(0, 1'b1, 1'b1, 2'd1, 16'h5AA5, LAT_WR_DUAL, 16'h0000, "dual_write");
      checks++;
      if (dev_mem[1] !== 8'hA5 || dev_mem[2] !== 8'h5A) begin
         failures++;
         $display("FAIL dual_write_mem: mem[1]=%h mem[2]=%h, required a5 5a", dev_mem[1], dev_mem[2]);
      end
      do_req(1, 1'b0, 1'b1, 2'd1, 16'h0000, LAT_RD_DUAL, 16'h5AA5, "dual_read");
   endtask

   task automatic test_wrap();
      do_req(0, 1'b1, 1'b1, 2'd3, 16'h2211, LAT_WR_DUAL, 16'h0000, "wrap_write");
      do_req(0, 1'b0, 1'b0, 2'd3, 16'h0000, LAT_RD_SINGLE, 16'h0011, "wrap_read3");
      do_req(1, 1'b0, 1'b0, 2'd0, 16'h0000, LAT_RD_SINGLE, 16'h0022, "wrap_read0");
   endtask

   task automatic test_back_to_back();
      int n;
      int g_idx [4];
      int g_cyc [4];
      int dual_seen;
      int both_seen;
      int multi_rdy;
      n = 0; dual_seen = 0; both_seen = 0; multi_rdy = 0;
      @(negedge clk);
      drive_req(0, 1'b1, 1'b0, 2'd0, 16'h0030);
      drive_req(1, 1'b1, 1'b0, 2'd1, 16'h0031);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (mem_write_dual_en !== 1'b0 || mem_read_dual_en !== 1'b0) dual_seen++;
         if (mem_write_en && mem_read_en) both_seen++;
         if (req_ready[0] && req_ready[1]) multi_rdy++;
         if (req_ready !== '0) begin
            g_idx[n] = req_ready[1] ? 1 : 0;
            g_cyc[n] = cyc;
            n++;
         end
         if (n == 4) begin
            @(posedge clk);
            #1 req_valid = '0;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL b2b_count: got %0d accepts, required 4", n);
      end else begin
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (g_idx[j] != (j % 2)) begin
               failures++;
               $display("FAIL b2b_grant%0d: got req%0d, required req%0d", j, g_idx[j], j % 2);
            end
         end
         for (int j = 1; j < 4; j++) begin
            checks++;
            if (g_cyc[j] - g_cyc[j-1] != LAT_WR_SINGLE + 1) begin
               failures++;
               $display("FAIL b2b_spacing%0d: got %0d, required %0d", j,
                        g_cyc[j] - g_cyc[j-1], LAT_WR_SINGLE + 1);
            end
         end
      end
      repeat (4) begin
         @(negedge clk);
         if (mem_write_dual_en !== 1'b0 || mem_read_dual_en !== 1'b0) dual_seen++;
      end
      checks++;
      if (dual_seen != 0 || both_seen != 0 || multi_rdy != 0) begin
         failures++;
         $display("FAIL b2b_enables: dual_cycles=%0d both_en_cycles=%0d multi_ready=%0d, required 0 0 0",
                  dual_seen, both_seen, multi_rdy);
      end
      checks++;
      if (dev_mem[0] !== 8'h30 || dev_mem[1] !== 8'h31) begin
         failures++;
         $display("FAIL b2b_mem: mem[0]=%h mem[1]=%h, required 30 31", dev_mem[0], dev_mem[1]);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int rv_seen;
      rv_seen = 0;
      @(negedge clk);
      drive_req(0, 1'b1, 1'b1, 2'd0, 16'hBBAA);
      #1;
      k = 0;
      while (req_ready[0] !== 1'b1 && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      checks++;
      if (k >= 20) begin
         failures++;
         $display("FAIL rstmid_accept: req_ready=%b, required bit 0 set", req_ready);
      end
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_write_en !== 1'b1 || mem_address !== 2'd0 || mem_data_wr !== 8'hAA) begin
         failures++;
         $display("FAIL rstmid_issue0: we=%b a=%h d=%h, required 1 0 aa", mem_write_en, mem_address, mem_data_wr);
      end
      @(negedge clk);
      checks++;
      if (mem_write_en !== 1'b1 || mem_address !== 2'd1 || mem_data_wr !== 8'hBB) begin
         failures++;
         $display("FAIL rstmid_issue1: we=%b a=%h d=%h, required 1 1 bb", mem_write_en, mem_address, mem_data_wr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, mem_address, mem_write_en, mem_read_en,
           mem_write_dual_en, mem_read_dual_en, mem_data_wr} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs: rv=%b a=%h we=%b re=%b wd=%h, required all 0",
                  rsp_valid, mem_address, mem_write_en, mem_read_en, mem_data_wr);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== '0) rv_seen++;
      end
      checks++;
      if (rv_seen != 0) begin
         failures++;
         $display("FAIL rstmid_no_rsp: rsp_valid seen in %0d cycles, required 0", rv_seen);
      end
      drive_req(0, 1'b1, 1'b0, 2'd2, 16'h0044);
      drive_req(1, 1'b1, 1'b0, 2'd3, 16'h0055);
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL rstmid_priority: req_ready=%b, required 01", req_ready);
      end
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(negedge clk);
   endtask

`ifdef MEM_ACCESS_CTRL_GRANT_CNT_EN
   task automatic test_grant_cnt();
      // One req0 accept already happened since the last reset.
      for (int j = 0; j < 4; j++)
         do_req(0, 1'b1, 1'b0, 2'd0, 16'h0001, LAT_WR_SINGLE, 16'h0000, "cnt_req0");
      for (int j = 0; j < 3; j++)
         do_req(1, 1'b1, 1'b0, 2'd1, 16'h0002, LAT_WR_SINGLE, 16'h0000, "cnt_req1");
      checks++;
      if (grant_cnt !== {16'd3, 16'd5}) begin
         failures++;
         $display("FAIL grant_cnt: got %h, required %h", grant_cnt, {16'd3, 16'd5});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_dual();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
`ifdef MEM_ACCESS_CTRL_GRANT_CNT_EN
      test_grant_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
